seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 168 ++++++++++++++++
 tb/tb_seq_divider.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int              CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_shq;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_dvd;
   logic             r_dz;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rmd;
   logic             r_dz_o;

   logic             w_accept;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH-1:0] w_q_res;
   logic [WIDTH-1:0] w_r_res;

   // busy also covers the done cycle, so gating on it blocks a start sampled there.
   assign w_accept = (r_state == S_IDLE) && start && !r_busy;
   assign w_shift  = {r_rem, r_shq[WIDTH-1]};
   assign w_trial  = w_shift - {1'b0, r_dvs};

`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic r_neg_q;
   logic r_neg_r;
   logic r_ovf;
   logic r_ovf_o;
   logic w_ovf_res;

   assign w_a_mag = dividend[WIDTH-1] ? -dividend : dividend;
   assign w_b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

   always_comb begin
      w_ovf_res = 1'b0;
      w_q_res   = r_neg_q ? -r_shq : r_shq;
      w_r_res   = r_neg_r ? -r_rem : r_rem;
      if (r_dz) begin
         w_q_res = '1;
         w_r_res = r_dvd;
      end else if (r_ovf) begin
         w_q_res   = MOST_NEG;
         w_r_res   = '0;
         w_ovf_res = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_ovf   <= 1'b0;
         r_ovf_o <= 1'b0;
      end else if (w_accept) begin
         r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         r_neg_r <= dividend[WIDTH-1];
         r_ovf   <= (dividend == MOST_NEG) && (divisor == '1);
      end else if (r_state == S_DONE) begin
         r_ovf_o <= w_ovf_res;
      end
   end

   assign overflow = r_ovf_o;
`else
   assign w_a_mag = dividend;
   assign w_b_mag = divisor;

   always_comb begin
      w_q_res = r_dz ? '1 : r_shq;
      w_r_res = r_dz ? r_dvd : r_rem;
   end

   assign overflow = 1'b0;
`endif

   // A zero divisor makes one pass through RUN so its done lands two edges after start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_shq   <= '0;
         r_dvs   <= '0;
         r_dvd   <= '0;
         r_dz    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_quot  <= '0;
         r_rmd   <= '0;
         r_dz_o  <= 1'b0;
      end else begin
         r_busy <= (r_state != S_IDLE);
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_dvd   <= dividend;
                  r_shq   <= w_a_mag;
                  r_dvs   <= w_b_mag;
                  r_rem   <= '0;
                  r_dz    <= (divisor == '0);
                  r_cnt   <= (divisor == '0) ? '0 : CNT_LAST;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (!w_trial[WIDTH]) begin
                  r_rem <= w_trial[WIDTH-1:0];
                  r_shq <= {r_shq[WIDTH-2:0], 1'b1};
               end else begin
                  r_rem <= w_shift[WIDTH-1:0];
                  r_shq <= {r_shq[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt - CNT_ONE;
               if (r_cnt == '0) r_state <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b1;
               r_quot  <= w_q_res;
               r_rmd   <= w_r_res;
               r_dz_o  <= r_dz;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quot;
   assign remainder   = r_rmd;
   assign div_by_zero = r_dz_o;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases with literal results, then randomized
// start/operand traffic checked every cycle against a transaction-level model.
module tb_seq_divider;

   localparam int W = 8;
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam logic [W-1:0] Q_200_7 = 8'hF8;   // -56 / 7
   localparam logic [W-1:0] R_200_7 = 8'h00;
`else
   localparam logic [W-1:0] Q_200_7 = 8'd28;
   localparam logic [W-1:0] R_200_7 = 8'd4;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero, overflow;
   logic [W-1:0] quotient, remainder;

   int checks = 0;
   int errors = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference result packed as {quotient, remainder, div_by_zero, overflow}.
   function automatic logic [2*W+1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] q, r;
      if (b == '0) return {{W{1'b1}}, a, 1'b1, 1'b0};
`ifdef SEQ_DIVIDER_SIGNED_EN
      begin
         logic signed [W-1:0] sa, sb;
         if (a == MOST_NEG && b == '1) return {MOST_NEG, {W{1'b0}}, 1'b0, 1'b1};
         sa = a;
         sb = b;
         q = sa / sb;
         r = sa % sb;
      end
`else
      q = a / b;
      r = a % b;
`endif
      return {q, r, 1'b0, 1'b0};
   endfunction

   // Model: outputs expected after the most recent edge, advanced once per cycle.
   logic [2*W+1:0] exp_q[$];
   logic           m_inflight = 1'b0;
   int             m_t = 0;
   int             m_lat = 0;
   logic           e_busy = 1'b0, e_done = 1'b0, e_dz = 1'b0, e_ovf = 1'b0;
   logic [W-1:0]   e_q = '0, e_r = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_inflight = 1'b0;
         m_t = 0;
         exp_q.delete();
         e_busy = 1'b0; e_done = 1'b0; e_dz = 1'b0; e_ovf = 1'b0;
         e_q = '0; e_r = '0;
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("quotient", quotient, e_q);
      chk("remainder", remainder, e_r);
      chk("div_by_zero", div_by_zero, e_dz);
      chk("overflow", overflow, e_ovf);
      if (rst_n) begin
         if (!m_inflight) begin
            if (start) begin
               exp_q.push_back(ref_div(dividend, divisor));
               m_lat = (divisor == '0) ? 2 : W + 1;
               m_t = 0;
               m_inflight = 1'b1;
            end
         end else begin
            m_t++;
            if (m_t > m_lat) m_inflight = 1'b0;
         end
         e_busy = m_inflight && (m_t >= 1) && (m_t <= m_lat);
         e_done = m_inflight && (m_t == m_lat);
         if (e_done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard: done expected with empty queue");
            end else begin
               {e_q, e_r, e_dz, e_ovf} = exp_q.pop_front();
            end
         end
      end
   end

   task automatic wait_done(output int n);
      logic seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 64) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done within %0d cycles", n);
      end
   endtask

   // Issue one start pulse; returns edges from the sampling edge to done.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      @(posedge clk);
      #2 start = 1'b1; dividend = a; divisor = b;
      @(posedge clk);
      #2 start = 1'b0; dividend = $urandom; divisor = $urandom;
      wait_done(lat);
   endtask

   initial begin
      int lat;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_quot", quotient, 0);

      do_op(8'd200, 8'd7, lat);
      chk("lat_200_7", lat, W + 1);
      chk("q_200_7", quotient, Q_200_7);
      chk("r_200_7", remainder, R_200_7);
      chk("dz_200_7", div_by_zero, 0);

      do_op(8'd5, 8'd0, lat);
      chk("lat_div0", lat, 2);
      chk("q_div0", quotient, 8'hFF);
      chk("r_div0", remainder, 8'd5);
      chk("dz_div0", div_by_zero, 1);

      do_op(8'd255, 8'd1, lat);
      chk("q_255_1", quotient, 8'hFF);
      chk("r_255_1", remainder, 0);
      chk("dz_cleared", div_by_zero, 0);

      // Second start while busy is ignored.
      @(posedge clk);
      #2 start = 1'b1; dividend = 8'd100; divisor = 8'd9;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (2) @(posedge clk);
      #2 start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      @(posedge clk);
      #2 start = 1'b0;
      wait_done(lat);
      chk("lat_ignored", lat, W - 2);
      chk("q_100_9", quotient, 8'd11);
      chk("r_100_9", remainder, 8'd1);
      do_op(8'd50, 8'd5, lat);
      chk("lat_b2b", lat, W + 1);
      chk("q_50_5", quotient, 8'd10);
      chk("r_50_5", remainder, 8'd0);

      // Reset mid-operation.
      @(posedge clk);
      #2 start = 1'b1; dividend = 8'd200; divisor = 8'd7;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_quot", quotient, 0);
      chk("abort_rem", remainder, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      do_op(8'd13, 8'd13, lat);
      chk("q_13_13", quotient, 8'd1);
      chk("r_13_13", remainder, 8'd0);

`ifdef SEQ_DIVIDER_SIGNED_EN
      do_op(8'h9C, 8'd7, lat);
      chk("q_m100_7", quotient, 8'hF2);
      chk("r_m100_7", remainder, 8'hFE);
      do_op(8'h80, 8'hFF, lat);
      chk("lat_ovf", lat, W + 1);
      chk("ovf_flag", overflow, 1);
      chk("q_ovf", quotient, 8'h80);
      chk("r_ovf", remainder, 8'h00);
`else
      do_op(8'h9C, 8'd7, lat);
      chk("q_156_7", quotient, 8'd22);
      chk("r_156_7", remainder, 8'd2);
      chk("ovf_off", overflow, 0);
`endif

      // Random traffic: start and operands toggle freely, including while busy.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #2;
         start = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 9))
            0:       begin dividend = $urandom; divisor = '0; end
            1:       begin dividend = MOST_NEG; divisor = '1; end
            2:       begin dividend = $urandom; divisor = W'($urandom_range(1, 4)); end
            default: begin dividend = $urandom; divisor = $urandom; end
         endcase
      end
      #2 start = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("drain_queue", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
